// File: rtl/i_mem_fill_ctrl_if.sv
// Fill-engine bus: cache-side miss request/response plus word memory port.
// master = cache/memory side, slave = fill controller.
interface i_mem_fill_ctrl_if;
  logic         fill_req_valid;
  logic [31:0]  fill_req_address;
  logic         mem_rd_en;
  logic [31:0]  mem_rd_addr;
  logic [31:0]  mem_rd_data;
  logic         fill_rsp_valid;
  logic [31:0]  fill_rsp_address;
  logic [127:0] fill_rsp_cl;
  logic         busy;
  logic         fill_req_drop;

  modport master (
    output fill_req_valid,
    output fill_req_address,
    output mem_rd_data,
    input  mem_rd_en,
    input  mem_rd_addr,
    input  fill_rsp_valid,
    input  fill_rsp_address,
    input  fill_rsp_cl,
    input  busy,
    input  fill_req_drop
  );

  modport slave (
    input  fill_req_valid,
    input  fill_req_address,
    input  mem_rd_data,
    output mem_rd_en,
    output mem_rd_addr,
    output fill_rsp_valid,
    output fill_rsp_address,
    output fill_rsp_cl,
    output busy,
    output fill_req_drop
  );
endinterface

// File: rtl/i_mem_fill_ctrl.sv
// I-cache miss-fill engine: four word reads assembled into one 128-bit line.
// Optional macro CRITICAL_WORD_FIRST_EN: issue reads starting at the missed word.
module i_mem_fill_ctrl #(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  i_mem_fill_ctrl_if.slave bus
);

  localparam int CL_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t       r_state;
  logic [31:0]  r_addr;
  logic [1:0]   r_cnt;
  logic [3:0]   r_mask;
  logic [31:0]  r_line [CL_WORDS];

  logic [MEM_RD_LATENCY-1:0] r_pv;
  logic [1:0]   r_pi [MEM_RD_LATENCY];

  logic         r_rd_en;
  logic [31:0]  r_rd_addr;
  logic [1:0]   r_rd_idx;
  logic         r_rsp_valid;
  logic [31:0]  r_rsp_addr;
  logic [127:0] r_rsp_cl;
  logic         r_busy;
  logic         r_drop;

  logic         w_tail_v;
  logic [1:0]   w_tail_i;
  logic [3:0]   w_mask_nxt;
  logic [127:0] w_line_nxt;
  logic [1:0]   w_first;
  logic [1:0]   w_next;

  assign w_tail_v = r_pv[MEM_RD_LATENCY-1];
  assign w_tail_i = r_pi[MEM_RD_LATENCY-1];

  // Line as it will look after this cycle's returning word lands
  always_comb begin
    w_mask_nxt = r_mask;
    w_line_nxt = '0;
    if (w_tail_v) w_mask_nxt[w_tail_i] = 1'b1;
    for (int k = 0; k < CL_WORDS; k++) begin
      if (w_tail_v && w_tail_i == 2'(k))
        w_line_nxt[32*k +: 32] = bus.mem_rd_data;
      else
        w_line_nxt[32*k +: 32] = r_line[k];
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_first = bus.fill_req_address[3:2];
  assign w_next  = r_addr[3:2] + r_cnt + 2'd1;
`else
  assign w_first = 2'd0;
  assign w_next  = r_cnt + 2'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_pv        <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_idx    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_cl    <= '0;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
      for (int k = 0; k < MEM_RD_LATENCY; k++)
        r_pi[k] <= '0;
      for (int k = 0; k < CL_WORDS; k++)
        r_line[k] <= '0;
    end else begin
      r_pv[0] <= r_rd_en;
      r_pi[0] <= r_rd_idx;
      for (int k = 1; k < MEM_RD_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pi[k] <= r_pi[k-1];
      end
      r_mask <= w_mask_nxt;
      for (int k = 0; k < CL_WORDS; k++)
        r_line[k] <= w_line_nxt[32*k +: 32];
      r_drop      <= bus.fill_req_valid && (r_state != IDLE);
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.fill_req_valid) begin
            r_addr    <= bus.fill_req_address;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_idx  <= w_first;
            r_rd_addr <= {bus.fill_req_address[31:4],
                          w_first, 2'b00};
            r_busy    <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cnt == 2'(CL_WORDS-1)) begin
            r_rd_en <= 1'b0;
            r_state <= WAIT;
          end else begin
            r_cnt     <= r_cnt + 2'd1;
            r_rd_idx  <= w_next;
            r_rd_addr <= {r_addr[31:4], w_next, 2'b00};
          end
        end
        WAIT: begin
          if (&w_mask_nxt) begin
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= r_addr;
            r_rsp_cl    <= w_line_nxt;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en        = r_rd_en;
  assign bus.mem_rd_addr      = r_rd_addr;
  assign bus.fill_rsp_valid   = r_rsp_valid;
  assign bus.fill_rsp_address = r_rsp_addr;
  assign bus.fill_rsp_cl      = r_rsp_cl;
  assign bus.busy             = r_busy;
  assign bus.fill_req_drop    = r_drop;

endmodule
